// File: rtl/cardinal_nic_fifo.sv
// Cardinal NIC with a DEPTH-entry FIFO in each direction.
//
// Connects one Cardinal CPU node to its ring router.
//   clk, reset          : system clock, synchronous active-high reset
//   addr, d_in, d_out   : CPU register port
//                         (00 in-data, 01 in-status, 10 out-data, 11 out-status)
//   nicEn, nicWrEn      : CPU access enable / write select
//   net_si, net_ri      : router -> NIC send / NIC ready
//   net_di              : router -> NIC packet
//   net_so, net_ro      : NIC -> router send / router ready
//   net_do              : NIC -> router packet
//   net_polarity        : router's even/odd cycle; gates injection by head VC (bit 0)
//
// Data ordering is [0:DATA_W-1] with bit 0 as the MSB. Status bits are
// returned in d_out[DATA_W-1].
module cardinal_nic_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  localparam logic [1:0] AddrInData    = 2'b00;
  localparam logic [1:0] AddrInStatus  = 2'b01;
  localparam logic [1:0] AddrOutData   = 2'b10;
  localparam logic [1:0] AddrOutStatus = 2'b11;

  localparam logic [PTR_W:0] PtrOne = {{PTR_W{1'b0}}, 1'b1};

  // Storage
  logic [0:DATA_W-1] in_mem  [DEPTH];
  logic [0:DATA_W-1] out_mem [DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [PTR_W:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;

  logic in_full, in_empty, out_full, out_empty;
  logic in_push, in_pop, out_push, out_pop;
  logic cpu_rd, cpu_wr;
  logic [0:DATA_W-1] in_head, out_head;

  assign in_empty  = (in_wr_q == in_rd_q);
  assign in_full   = (in_wr_q[PTR_W] != in_rd_q[PTR_W]) &&
                     (in_wr_q[PTR_W-1:0] == in_rd_q[PTR_W-1:0]);
  assign out_empty = (out_wr_q == out_rd_q);
  assign out_full  = (out_wr_q[PTR_W] != out_rd_q[PTR_W]) &&
                     (out_wr_q[PTR_W-1:0] == out_rd_q[PTR_W-1:0]);

  assign in_head  = in_mem[in_rd_q[PTR_W-1:0]];
  assign out_head = out_mem[out_rd_q[PTR_W-1:0]];

  assign cpu_rd = nicEn && !nicWrEn;
  assign cpu_wr = nicEn && nicWrEn;

  // Handshake outputs; all forced low while reset is held.
  always_comb begin
    net_ri = !reset && !in_full;
    net_so = !reset && !out_empty && net_ro && (out_head[0] == net_polarity);
    net_do = (reset || out_empty) ? '0 : out_head;
  end

  // Push/pop decisions are taken from the pre-edge counts, so a full FIFO
  // that is popped this cycle still refuses the push.
  always_comb begin
    in_push  = !reset && net_si && !in_full;
    in_pop   = !reset && cpu_rd && (addr == AddrInData) && !in_empty;
    out_push = !reset && cpu_wr && (addr == AddrOutData) && !out_full;
    out_pop  = net_so;
  end

  always_comb begin
    in_wr_d  = in_push  ? in_wr_q  + PtrOne : in_wr_q;
    in_rd_d  = in_pop   ? in_rd_q  + PtrOne : in_rd_q;
    out_wr_d = out_push ? out_wr_q + PtrOne : out_wr_q;
    out_rd_d = out_pop  ? out_rd_q + PtrOne : out_rd_q;
  end

  // CPU read mux
  always_comb begin
    d_out = '0;
    if (!reset && cpu_rd) begin
      unique case (addr)
        AddrInData:    d_out = in_empty ? '0 : in_head;
        AddrInStatus:  d_out[DATA_W-1] = !in_empty;
        AddrOutData:   d_out = '0;
        AddrOutStatus: d_out[DATA_W-1] = out_full;
        default:       d_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      out_wr_q <= '0;
      out_rd_q <= '0;
    end else begin
      in_wr_q  <= in_wr_d;
      in_rd_q  <= in_rd_d;
      out_wr_q <= out_wr_d;
      out_rd_q <= out_rd_d;
    end
  end

  // Storage needs no reset; entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (in_push) begin
      in_mem[in_wr_q[PTR_W-1:0]] <= net_di;
    end
    if (out_push) begin
      out_mem[out_wr_q[PTR_W-1:0]] <= d_in;
    end
  end

endmodule

// File: doc/cardinal_nic_fifo.md
Name: cardinal_nic_fifo

Overview:
Network interface between one Cardinal CPU node and its ring router in the 4-node CMP. The CPU side is a 4-register memory-mapped port (addr/d_in/d_out/nicEn/nicWrEn). The router side uses a send/ready handshake in each direction. Each direction has a DEPTH-entry FIFO, so the CPU can queue back-to-back packets and the ring can deliver packets faster than the CPU drains them. Output injection is gated by the router's even/odd VC polarity.

Parameters:
DATA_W, 64, packet/data width (bit 0 = MSB, [0:DATA_W-1] ordering)
DEPTH, 4, entries per FIFO; power of 2, >=2
PTR_W, 2, log2(DEPTH); pointers are PTR_W+1 bits to distinguish full from empty

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
addr  in  2  CPU register select: 00 in-data, 01 in-status, 10 out-data, 11 out-status
d_in  in  DATA_W  CPU write data
d_out  out  DATA_W  CPU read data
nicEn  in  1  CPU access enable
nicWrEn  in  1  1 = write, 0 = read (valid only with nicEn)
net_si  in  1  router sends a packet to the NIC this cycle
net_ri  out  1  NIC can accept a packet from the router
net_di  in  DATA_W  packet from router
net_so  out  1  NIC sends a packet to the router this cycle
net_ro  in  1  router can accept a packet from the NIC
net_do  out  DATA_W  packet to router
net_polarity  in  1  router's current cycle polarity (0 even, 1 odd)

Behaviour:
- Packet format: [0] VC, [1] direction, [2:7] reserved, [8:15] hop count, [16:31] source, [32:63] payload. The NIC never modifies packet fields.
- Reset (sampled at posedge): both FIFOs empty; all pointers 0.
  - While reset=1, these outputs are forced to 0: net_ri, net_so, d_out, net_do.
  - net_ri rises on the first cycle after reset is released.
- Input FIFO (router to CPU):
  - net_ri = !in_full (combinational from registered count).
  - Push on posedge when net_si && net_ri; net_si while !net_ri is ignored and causes no corruption.
  - CPU read of addr 00 (nicEn && !nicWrEn): d_out = head combinationally, same cycle.
    - Pop on that posedge if non-empty.
    - If empty: d_out = 0, no pop, no pointer change.
  - CPU read of addr 01: d_out[DATA_W-1] = !in_empty; all other bits 0.
  - Simultaneous push and pop when neither full nor empty: both occur, count unchanged.
  - When full: pop allowed. net_ri is still 0 that cycle (based on pre-edge count), so no push.
- Output FIFO (CPU to router):
  - CPU write of addr 10 (nicEn && nicWrEn): push d_in on posedge if !out_full. A write while full is dropped; FIFO unchanged.
  - CPU read of addr 11: d_out[DATA_W-1] = out_full; all other bits 0.
  - net_do = head of output FIFO (0 when empty).
  - net_so = !out_empty && net_ro && (head[0] == net_polarity). This is combinational, with no additional latency.
  - Pop on posedge when net_so=1. A head whose VC mismatches the polarity waits (head-of-line); it is neither reordered nor dropped.
  - CPU push and router pop in the same cycle: both occur.
- Ignored accesses:
  - Writes to addr 00/01/11: no effect.
  - Read of addr 10: d_out = 0.
  - nicEn=0: d_out = 0, no state change.
- Pointer wrap: read/write pointers increment modulo 2*DEPTH. Full = MSBs differ and LSBs equal; empty = pointers equal.
- Latency:
  - Router push to CPU-visible status = 1 cycle.
  - CPU write to earliest net_so = 1 cycle.
- Reset asserted mid-transfer: reset wins over any push or pop on that edge; both FIFOs empty next cycle.

Test Plan:
- Reset then idle: reset 5 cycles -> net_ri=0, net_so=0, d_out=0 during reset; net_ri=1 on the first cycle after release; addr 01 read returns 0; addr 11 read returns 0.
- Input fill/overflow: router pushes 5 packets 64'h0000_0000_0000_0011..15 with net_si held -> net_ri falls after the 4th push; 5th is held off. CPU reads addr 00 four times -> returns ..11..14 in order. addr 01 then reads 0.
- Output polarity gating: CPU writes 64'h8000_0000_0000_00AA (VC=1) with net_ro=1 and net_polarity toggling from 0 -> net_so asserts only in the polarity=1 cycle; net_do=8000_0000_0000_00AA; FIFO empties after that edge.
- Output full and drop: net_ro=0, CPU writes 5 words A0..A4 -> addr 11 reads 1 after the 4th write. Release net_ro with matching polarity -> exactly A0..A3 are sent in order; A4 never appears.
- Simultaneous traffic and wrap: 20 cycles of concurrent router push + CPU pop, and CPU push + router pop (pointers wrap at least twice) -> no loss, no reordering; the count stays consistent with the status bits.
- Reset mid-operation: both FIFOs holding 2 entries, assert reset for 1 cycle -> both status reads 0; net_so=0; subsequent traffic starts at pointer 0 and is correct.
